// File: rtl/mux_8_1_pkg.sv
// Shared constants for the 8:1 registered bit multiplexer.
package mux_8_1_pkg;

  localparam int unsigned N_IN        = 8;
  localparam int unsigned SEL_W       = 3;
  localparam logic        OUT_RST_VAL = 1'b0;

endpackage : mux_8_1_pkg

// File: rtl/mux_2_1.sv
// 2:1 single-bit multiplexer leaf cell; s=0 passes a, s=1 passes b.
module mux_2_1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  // Leaf select.
  always_comb begin
    y = s ? b : a;
  end

endmodule : mux_2_1

// File: rtl/mux_8_1_v_cmpnt.sv
// 8:1 bit multiplexer built as a 3-level mux_2_1 tree, enable-gated after
// the tree and registered with a synchronous active-low reset.
// Optional: define MUX_8_1_VALID_EN to add o_valid, a registered copy of i_en.
module mux_8_1_v_cmpnt
  import mux_8_1_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [N_IN-1:0]  i_code,
  input  logic [SEL_W-1:0] i_sel_code,
`ifdef MUX_8_1_VALID_EN
  output logic             o_valid,
`endif
  output logic             o_f
);

  logic [3:0] lvl1;
  logic [1:0] lvl2;
  logic       lvl3;
  logic       f_d;
  logic       f_q;

  // Level 1: pairs of adjacent candidates, steered by select bit 0.
  mux_2_1 u_l1_0 (.a(i_code[0]), .b(i_code[1]), .s(i_sel_code[0]), .y(lvl1[0]));
  mux_2_1 u_l1_1 (.a(i_code[2]), .b(i_code[3]), .s(i_sel_code[0]), .y(lvl1[1]));
  mux_2_1 u_l1_2 (.a(i_code[4]), .b(i_code[5]), .s(i_sel_code[0]), .y(lvl1[2]));
  mux_2_1 u_l1_3 (.a(i_code[6]), .b(i_code[7]), .s(i_sel_code[0]), .y(lvl1[3]));

  // Level 2: steered by select bit 1.
  mux_2_1 u_l2_0 (.a(lvl1[0]), .b(lvl1[1]), .s(i_sel_code[1]), .y(lvl2[0]));
  mux_2_1 u_l2_1 (.a(lvl1[2]), .b(lvl1[3]), .s(i_sel_code[1]), .y(lvl2[1]));

  // Level 3: steered by select bit 2.
  mux_2_1 u_l3_0 (.a(lvl2[0]), .b(lvl2[1]), .s(i_sel_code[2]), .y(lvl3));

  // Enable gating applied after the tree output.
  always_comb begin
    f_d = i_en & lvl3;
  end

  // Output register; reset overrides every other input.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      f_q <= OUT_RST_VAL;
    end else begin
      f_q <= f_d;
    end
  end

  assign o_f = f_q;

`ifdef MUX_8_1_VALID_EN
  logic valid_q;

  // Registered copy of the enable, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= i_en;
    end
  end

  assign o_valid = valid_q;
`else
`endif

endmodule : mux_8_1_v_cmpnt

// File: tb/tb_mux_8_1_v_cmpnt.sv
// Self-checking bench for mux_8_1_v_cmpnt: directed table, hold/reset
// sequences, exhaustive sweep and random vectors against a reference model.
module tb_mux_8_1_v_cmpnt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] code;
  logic [2:0] sel;
  logic       f;
`ifdef MUX_8_1_VALID_EN
  logic       valid;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mux_8_1_v_cmpnt dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_code     (code),
    .i_sel_code (sel),
`ifdef MUX_8_1_VALID_EN
    .o_valid    (valid),
`endif
    .o_f        (f)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] code;
    logic [2:0] sel;
    logic       exp_f;
  } vec_t;

  // Reference: selected candidate = bit number sel of the code value.
  function automatic logic ref_f(logic r, logic e, logic [7:0] c, logic [2:0] s);
    int unsigned cv;
    int unsigned sv;
    if (r !== 1'b1) return 1'b0;
    if (e !== 1'b1) return 1'b0;
    cv = int'(c);
    sv = int'(s);
    return ((cv / (1 << sv)) % 2) == 1;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (rst_n=%b en=%b code=%h sel=%0d)",
               name, act, exp, rst_n, en, code, sel);
    end
  endtask

  // Drive one set of inputs, clock once, check against the reference model.
  task automatic apply_edge(input logic r, input logic e, input logic [7:0] c,
                            input logic [2:0] s, input string name);
    rst_n = r; en = e; code = c; sel = s;
    @(posedge clk); #1;
    check(name, f, ref_f(r, e, c, s));
`ifdef MUX_8_1_VALID_EN
    check({name, "_valid"}, valid, r & e);
`endif
  endtask

  vec_t tbl[12];

  initial begin
    rst_n = 1'b0; en = 1'b0; code = '0; sel = '0;

    tbl[0]  = '{1'b0, 1'b1, 8'hFF, 3'd7, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hFF, 3'd7, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h04, 3'd2, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'h04, 3'd3, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'hFF, 3'd5, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'h80, 3'd7, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h80, 3'd7, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'hFE, 3'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h7F, 3'd7, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h20, 3'd5, 1'b1};

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; code = tbl[i].code; sel = tbl[i].sel;
      @(posedge clk); #1;
      check($sformatf("table%0d", i), f, tbl[i].exp_f);
`ifdef MUX_8_1_VALID_EN
      check($sformatf("table%0d_valid", i), valid, tbl[i].rst_n & tbl[i].en);
`endif
    end

    // Inputs changing between edges must not disturb the output.
    apply_edge(1'b1, 1'b1, 8'h80, 3'd7, "hold_setup");
    en = 1'b0; code = 8'h00; sel = 3'd0;
    #3;
    check("hold_inputs", f, 1'b1);
    rst_n = 1'b0;
    #2;
    check("hold_reset", f, 1'b1);
    @(posedge clk); #1;
    check("sync_reset", f, 1'b0);
    apply_edge(1'b1, 1'b1, 8'h80, 3'd7, "resume");

    // Simultaneous change of every input before one edge.
    apply_edge(1'b1, 1'b0, 8'h00, 3'd0, "simul_a");
    apply_edge(1'b1, 1'b1, 8'h08, 3'd3, "simul_b");

`ifdef MUX_8_1_VALID_EN
    // Enable toggle seen on o_valid one cycle later.
    apply_edge(1'b1, 1'b1, 8'h00, 3'd0, "vtog1");
    check("vtog1_explicit", valid, 1'b1);
    apply_edge(1'b1, 1'b0, 8'h00, 3'd0, "vtog0");
    check("vtog0_explicit", valid, 1'b0);
    apply_edge(1'b1, 1'b1, 8'h00, 3'd0, "vtog2");
    check("vtog2_explicit", valid, 1'b1);
`endif

    // Exhaustive sweep of {en, sel, code}.
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] v;
      v = 12'(i);
      apply_edge(1'b1, v[11], v[7:0], v[10:8], "sweep");
    end

    // Random vectors with occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(15) != 0);
      apply_edge(r, 1'($urandom), 8'($urandom), 3'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_mux_8_1_v_cmpnt
